// File: rtl/seg_pipe_adder.sv
// Segmented pipelined adder/subtractor: one SEG-bit slice per stage, carries registered between
// stages, with signed overflow detection and optional saturation on the final stage.
module seg_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             op_sub,
    input  logic             sat,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned NSEG = WIDTH / SEG;

    logic             adv;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // The whole pipe advances together; it only freezes when a finished result is refused.
    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        // IW: operand bits not yet consumed entering this stage; DW: result bits known leaving it.
        localparam int unsigned IW = WIDTH - k * SEG;
        localparam int unsigned DW = (k + 1) * SEG;

        logic          v_in;
        logic          sub_in;
        logic          sat_in;
        logic          c_in;
        logic [IW-1:0] a_in;
        logic [IW-1:0] b_in;
        logic [DW-1:0] sum_d;
        logic [SEG:0]  seg;

        if (k == 0) begin : g_src
            assign v_in   = in_valid;
            assign sub_in = op_sub;
            assign sat_in = sat;
            assign c_in   = op_sub ^ Cin;
            assign a_in   = A;
            assign b_in   = B;
            assign sum_d  = seg[SEG-1:0];
        end else begin : g_chain
            assign v_in   = g_stage[k-1].g_mid.v_q;
            assign sub_in = g_stage[k-1].g_mid.sub_q;
            assign sat_in = g_stage[k-1].g_mid.sat_q;
            assign c_in   = g_stage[k-1].g_mid.c_q;
            assign a_in   = g_stage[k-1].g_mid.a_q;
            assign b_in   = g_stage[k-1].g_mid.b_q;
            assign sum_d  = {seg[SEG-1:0], g_stage[k-1].g_mid.sum_q};
        end

        // B travels uninverted; each stage applies the subtract inversion to its own slice.
        assign seg = {1'b0, a_in[SEG-1:0]}
                   + {1'b0, b_in[SEG-1:0] ^ {SEG{sub_in}}}
                   + {{SEG{1'b0}}, c_in};

        if (k < NSEG - 1) begin : g_mid
            localparam int unsigned RW = IW - SEG;

            logic          v_q;
            logic          sub_q;
            logic          sat_q;
            logic          c_q;
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            logic [DW-1:0] sum_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    sub_q <= 1'b0;
                    sat_q <= 1'b0;
                    c_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                end else if (adv) begin
                    v_q <= v_in;
                    if (v_in) begin
                        sub_q <= sub_in;
                        sat_q <= sat_in;
                        c_q   <= seg[SEG];
                        a_q   <= a_in[IW-1:SEG];
                        b_q   <= b_in[IW-1:SEG];
                        sum_q <= sum_d;
                    end
                end
            end
        end else begin : g_last
            logic             a_msb;
            logic             b_msb;
            logic             ovf_d;
            logic [WIDTH-1:0] res_d;

            assign a_msb = a_in[IW-1];
            assign b_msb = b_in[IW-1] ^ sub_in;
            assign ovf_d = (a_msb == b_msb) && (sum_d[WIDTH-1] != a_msb);

            always_comb begin
                res_d = sum_d;
                if (sat_in && ovf_d) begin
                    res_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end

            // Result registers only load on a valid item so they hold through bubbles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    cout_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (adv) begin
                    out_valid_q <= v_in;
                    if (v_in) begin
                        sum_q  <= res_d;
                        cout_q <= seg[SEG];
                        ovf_q  <= ovf_d;
                    end
                end
            end
        end
    end

endmodule

// File: doc/seg_pipe_adder.md
SEG_PIPE_ADDER -- requirements
Module: seg_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The block SHALL have parameter SEG, default 4: segment width in bits, with WIDTH a multiple of SEG; NSEG = WIDTH/SEG pipeline stages.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port A, input, WIDTH bits: operand A, two's complement.
REQ-006 The block SHALL have port B, input, WIDTH bits: operand B, two's complement.
REQ-007 The block SHALL have port Cin, input, 1 bit: carry-in for add, borrow-in for subtract.
REQ-008 The block SHALL have port op_sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-009 The block SHALL have port sat, input, 1 bit: 1 selects signed saturation of the result.
REQ-010 The block SHALL have port in_valid, input, 1 bit: the input operands are valid.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-012 The block SHALL have port Sum, output, WIDTH bits: result.
REQ-013 The block SHALL have port Cout, output, 1 bit: raw carry out of the MSB.
REQ-014 The block SHALL have port Ovf, output, 1 bit: signed overflow flag.
REQ-015 The block SHALL have port out_valid, output, 1 bit: the result outputs are valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.

Function
REQ-017 An input transfer SHALL occur on a clk edge where in_valid=1 and in_ready=1; an output transfer SHALL occur on a clk edge where out_valid=1 and out_ready=1.
REQ-018 Operand preparation: Beff = op_sub ? ~B : B; c0 = op_sub ? ~Cin : Cin; raw result = A + Beff + c0, truncated to WIDTH bits, with carry out of the MSB.
REQ-019 Pipelining: stage k (k = 0..NSEG-1) SHALL compute segment bits [k*SEG +: SEG] using the carry registered from stage k-1 (c0 for stage 0); operand segments not yet consumed SHALL travel in pipeline registers alongside.
REQ-020 Each stage SHALL carry a valid bit and the op_sub/sat flags of its item; the last stage registers drive Sum, Cout, Ovf and out_valid.
REQ-021 Latency: an item accepted at edge n SHALL appear with out_valid=1 after edge n+NSEG-1 when no stall occurs (NSEG=4 gives 3 edges; NSEG=1 gives the registered result after the accepting edge).
REQ-022 Throughput SHALL be one item per cycle while out_ready=1.
REQ-023 Stall: when out_valid=1 and out_ready=0, all stages SHALL hold their contents and in_ready SHALL be 0; otherwise in_ready SHALL be 1.
REQ-024 Bubbles (in_valid=0 on an edge with in_ready=1) SHALL propagate as invalid stages and SHALL NOT assert out_valid.
REQ-025 Ovf SHALL equal (A[MSB] == Beff[MSB]) AND (raw Sum[MSB] != A[MSB]).
REQ-026 Saturation: when sat=1 and Ovf=1, Sum SHALL be 0x7FFF..F if A[MSB]=0 and 0x80..0 if A[MSB]=1; when sat=0, Sum SHALL be the raw result; Cout and Ovf SHALL always be the raw values.
REQ-027 Sum, Cout and Ovf SHALL hold their last values while out_valid=0 or while the block is stalled.
REQ-028 Simultaneous output transfer and input acceptance on the same edge SHALL lose no item and duplicate no item.

Reset
REQ-029 While rst_n=0, all stage valid bits and out_valid SHALL be 0, and Sum, Cout, Ovf and all pipeline data registers SHALL be 0, regardless of clk.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight items, with no output after rst_n is deasserted until a new input is accepted.
REQ-031 While rst_n=0, in_ready SHALL be 1.

Verification (WIDTH=16, SEG=4)
REQ-032 Add: A=0x00FF, B=0x0001, Cin=0, op_sub=0 -> after 3 edges out_valid=1, Sum=0x0100, Cout=0, Ovf=0.
REQ-033 Carry ripple across segments: A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1, Ovf=0.
REQ-034 Subtract with saturation: A=0x8000, B=0x0001, op_sub=1, Cin=0, sat=1 -> Sum=0x8000, Ovf=1, Cout=1; the same with sat=0 -> Sum=0x7FFF.
REQ-035 Back-to-back stream: 8 consecutive items with out_ready=0 held for 5 cycles mid-stream -> in_ready=0 during the stall, and all 8 results arrive in order with no duplicates.
REQ-036 Reset mid-stream: rst_n pulsed low with 3 items in flight -> out_valid=0 immediately, Sum=0, and no stale items appear after release.
